shift_sequencer: RTL
====================

// Module: shift_sequencer
// PURPOSE
//  Multi-cycle controller in front of one New_nBit_Shift instance (parameters WIDTH, OP).
//  Accepts a shift request whose total amount may exceed the per-pass limit.
//  Splits it into legal passes, drives the shifter's packed shift word and re-circulates
//  the registered result until the full amount is applied.
//  Sits between the ALU operand/opcode stage and the writeback register.
//  Requests and results use valid/ready handshakes.
// PARAMETERS
//  WIDTH   4  data width; also the width of the shifter's in, shift, out and overflow ports
//  OP      0  shifter mode, passed to the instance: 0 logical, 1 arithmetic
//  AMT_W   8  width of the requested total shift amount
// PORTS
//  clk         in   1        rising-edge clock
//  rst_n       in   1        asynchronous, active-low reset
//  req_valid   in   1        request present
//  req_ready   out  1        block can accept a request (IDLE only)
//  req_data    in   WIDTH    operand
//  req_dir     in   1        direction bit, placed in shift[0]
//  req_fill    in   1        fill bit, placed in shift[WIDTH-1]
//  req_amt     in   AMT_W    total shift amount
//  rsp_valid   out  1        result valid
//  rsp_ready   in   1        consumer accepts the result
//  rsp_data    out  WIDTH    shifted result
//  rsp_ovf     out  WIDTH    sticky OR of the shifter overflow over all passes
//  busy        out  1        high in SHIFT or DONE
// BEHAVIOUR
//  Reset (async assert, sync deassert)
//   - State goes to IDLE; all internal registers clear.
//   - Outputs: req_ready=1, rsp_valid=0, rsp_data=0, rsp_ovf=0, busy=0.
//  Per-pass limit MAX_STEP
//   - dir=0: WIDTH-1.
//   - dir=1: WIDTH/2.
//   - Each pass chunk = min(remaining, MAX_STEP), and is never 0 during SHIFT.
//  Packed shift word
//   - shift = {fill, chunk[WIDTH-3:0], dir}.
//   - Shifter in = working data register.
//  State machine: IDLE -> SHIFT -> DONE -> IDLE
//   - IDLE: on req_valid & req_ready, latch data, dir, fill and amt into remaining; clear ovf_acc.
//     - If amt==0, go to DONE (data unchanged, ovf=0).
//     - Otherwise go to SHIFT.
//   - SHIFT: each cycle register data <= shifter out, ovf_acc |= shifter overflow,
//     remaining -= chunk. When the new remaining is 0, go to DONE.
//   - DONE: rsp_valid=1, with rsp_data and rsp_ovf stable until accepted.
//     On rsp_ready, go to IDLE. Hold indefinitely while rsp_ready=0 (backpressure).
//  Latency
//   - Accept to rsp_valid = ceil(amt/MAX_STEP) + 1 cycles.
//   - amt=0 gives 1 cycle.
//  Request side
//   - req_ready is combinationally equal to (state==IDLE).
//   - Request inputs are ignored outside IDLE.
//   - A new request is accepted at the earliest one cycle after the response handshake
//     (no bypass).
//  Arithmetic
//   - remaining is AMT_W bits, unsigned.
//   - Amounts >= WIDTH are still sequenced fully; there is no early clamp, so the pass
//     count is exact.
//  Reset mid-operation
//   - Any in-flight request is dropped and no response is produced.
// TESTING (WIDTH=4, OP=0: MAX_STEP is 3 for dir=0 and 2 for dir=1)
//  1. Reset
//     - Stimulus: assert rst_n=0 mid-SHIFT.
//     - Required: immediately req_ready=1, rsp_valid=0, rsp_data=0; no response after release.
//  2. Zero amount
//     - Stimulus: req_data=4'hA, amt=0.
//     - Required: rsp_valid 1 cycle after accept, rsp_data=4'hA, rsp_ovf=0.
//  3. Chunking, dir=0
//     - Stimulus: amt=5.
//     - Required: shifter amount field 3 then 2; rsp_valid 3 cycles after accept.
//  4. Chunking, dir=1
//     - Stimulus: amt=5.
//     - Required: amount field 2,2,1; rsp_valid 4 cycles after accept; result matches a
//       model that applies the shifter 3 times.
//  5. Backpressure
//     - Stimulus: rsp_ready=0 for 5 cycles in DONE.
//     - Required: rsp_data and rsp_ovf stable; req_ready=0; req_valid pulses ignored.
//  6. Back-to-back
//     - Stimulus: req_valid held high over two requests; rsp_ready=1.
//     - Required: second accept exactly 1 cycle after the first response handshake.
//     - Bench also sweeps all 16 data values x amt 0..9 x dir x fill against the
//       iterated-shifter model.

Source files
------------

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: splits a large shift amount into legal passes
// through one new_nbit_shift instance and re-circulates the result until done.

module new_nbit_shift #(
  parameter int WIDTH = 4,
  parameter int OP    = 0
) (
  input  logic [WIDTH-1:0] in,
  input  logic [WIDTH-1:0] shift,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] overflow
);

  logic [WIDTH-3:0]   amt_s;
  logic               fill_bit_s;
  logic [2*WIDTH-1:0] wide_s;
  logic [WIDTH-1:0]   fill_mask_s;

  // Shift word is {fill, amount, dir}; bits pushed off the end land in overflow
  always_comb begin
    amt_s = shift[WIDTH-2:1];
    if ((OP == 1) && shift[0]) begin
      fill_bit_s = in[WIDTH-1];
    end else begin
      fill_bit_s = shift[WIDTH-1];
    end
    if (shift[0]) begin
      wide_s      = {in, {WIDTH{1'b0}}} >> amt_s;
      fill_mask_s = ~({WIDTH{1'b1}} >> amt_s);
      out         = wide_s[2*WIDTH-1:WIDTH] | ({WIDTH{fill_bit_s}} & fill_mask_s);
      overflow    = wide_s[WIDTH-1:0];
    end else begin
      wide_s      = {{WIDTH{1'b0}}, in} << amt_s;
      fill_mask_s = ~({WIDTH{1'b1}} << amt_s);
      out         = wide_s[WIDTH-1:0] | ({WIDTH{fill_bit_s}} & fill_mask_s);
      overflow    = wide_s[2*WIDTH-1:WIDTH];
    end
  end

endmodule

module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int OP    = 0,
  parameter int AMT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic             req_dir,
  input  logic             req_fill,
  input  logic [AMT_W-1:0] req_amt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] rsp_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [AMT_W-1:0] STEP_LEFT  = AMT_W'(WIDTH - 1);
  localparam logic [AMT_W-1:0] STEP_RIGHT = AMT_W'(WIDTH / 2);

  state_t           state_r, state_next_s;
  logic [WIDTH-1:0] data_r, ovf_r;
  logic             dir_r, fill_r;
  logic [AMT_W-1:0] rem_r;
  logic [AMT_W-1:0] max_step_s, chunk_s, rem_next_s;
  logic [WIDTH-1:0] shift_word_s, shift_out_s, shift_ovf_s;

  // Pass chunk is the smaller of what is left and the per-direction limit
  always_comb begin
    if (dir_r) begin
      max_step_s = STEP_RIGHT;
    end else begin
      max_step_s = STEP_LEFT;
    end
    if (rem_r < max_step_s) begin
      chunk_s = rem_r;
    end else begin
      chunk_s = max_step_s;
    end
    rem_next_s   = rem_r - chunk_s;
    shift_word_s = {fill_r, chunk_s[WIDTH-3:0], dir_r};
  end

  new_nbit_shift #(
    .WIDTH (WIDTH),
    .OP    (OP)
  ) u_shift (
    .in       (data_r),
    .shift    (shift_word_s),
    .out      (shift_out_s),
    .overflow (shift_ovf_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_amt == {AMT_W{1'b0}}) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_SHIFT;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (rem_next_s == {AMT_W{1'b0}}) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state register
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    case (state_r)
      ST_IDLE:  req_ready = 1'b1;
      ST_SHIFT: busy      = 1'b1;
      ST_DONE: begin
        rsp_valid = 1'b1;
        busy      = 1'b1;
      end
      default: req_ready = 1'b0;
    endcase
  end

  // Working registers: latch on accept, re-circulate the shifter output each pass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= {WIDTH{1'b0}};
      ovf_r  <= {WIDTH{1'b0}};
      dir_r  <= 1'b0;
      fill_r <= 1'b0;
      rem_r  <= {AMT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            data_r <= req_data;
            ovf_r  <= {WIDTH{1'b0}};
            dir_r  <= req_dir;
            fill_r <= req_fill;
            rem_r  <= req_amt;
          end
        end
        ST_SHIFT: begin
          data_r <= shift_out_s;
          ovf_r  <= ovf_r | shift_ovf_s;
          rem_r  <= rem_next_s;
        end
        default: rem_r <= rem_r;
      endcase
    end
  end

  assign rsp_data = data_r;
  assign rsp_ovf  = ovf_r;

endmodule
